default_slave_write_resp: RTL and testbench

- AXI4 write-channel responder for unmapped addresses ("default slave", decoder output index 6) in the AXI bridge.
- Receives AW and W traffic that the M2S write decoder routes to no real slave.
- Consumes every data beat of the burst, discards the data, and returns one B response with DECERR.
- Keeps masters from hanging on illegal write addresses.

---
 rtl/default_slave_write_resp.sv | 141 ++++++++++++++
 tb/tb_default_slave_write_resp.sv | 224 ++++++++++++++++++++++
 2 files changed

// File: rtl/default_slave_write_resp.sv
// -----------------------------------------------------------------------------
// default_slave_write_resp
//
// Write-channel responder for addresses that decode to no real slave. It
// accepts one AW at a time, swallows every W beat of that burst without
// looking at the data, and answers with a single B carrying DECERR and the
// ID that arrived on AW. This keeps a master from stalling forever when it
// writes to an unmapped address.
//
// Ports:
//   ACLK, ARESETn             clock, asynchronous active-low reset
//   AWID_S .. AWVALID_S       write address channel in (only ID/LEN/VALID used)
//   AWREADY_S                 address ready, high only while idle
//   WDATA_S, WSTRB_S          write data, discarded
//   WLAST_S, WVALID_S         last-beat marker and data valid
//   WREADY_S                  data ready, high only while a burst is open
//   BID_S, BRESP_S, BVALID_S  write response out (BRESP_S is always DECERR)
//   BREADY_S                  response ready from the master
//
// Every output comes straight from a flop or a constant, so there is no
// combinational path from any input to any output.
// -----------------------------------------------------------------------------
module default_slave_write_resp #(
    parameter int IDW  = 8,
    parameter int LENW = 4,
    parameter int DW   = 32
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic [IDW-1:0]  AWID_S,
    input  logic [31:0]     AWADDR_S,
    input  logic [LENW-1:0] AWLEN_S,
    input  logic [2:0]      AWSIZE_S,
    input  logic [1:0]      AWBURST_S,
    input  logic            AWVALID_S,
    output logic            AWREADY_S,
    input  logic [DW-1:0]   WDATA_S,
    input  logic [DW/8-1:0] WSTRB_S,
    input  logic            WLAST_S,
    input  logic            WVALID_S,
    output logic            WREADY_S,
    output logic [IDW-1:0]  BID_S,
    output logic [1:0]      BRESP_S,
    output logic            BVALID_S,
    input  logic            BREADY_S
);

    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT,
        ST_IDLE,
        ST_DATA,
        ST_RESP
    } state_t;

    state_t          state;
    logic [LENW-1:0] beat_cnt;
    logic [LENW-1:0] burst_len;
    logic            aw_ready_q;
    logic            w_ready_q;
    logic            b_valid_q;
    logic [IDW-1:0]  b_id_q;

    // A burst closes on whichever comes first: the counted length or WLAST.
    // Closing on the count means the counter never has to wrap.
    logic last_beat;
    assign last_beat = (beat_cnt == burst_len) || WLAST_S;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            state      <= ST_INIT;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b0;
            b_id_q     <= '0;
            beat_cnt   <= '0;
            burst_len  <= '0;
        end else begin
            // NOTE: all state here uses non-blocking assignments so every
            // register samples the pre-edge values; blocking assignments
            // would let later lines see already-updated state.
            case (state)
                ST_INIT: begin
                    state      <= ST_IDLE;
                    aw_ready_q <= 1'b1;
                end

                ST_IDLE: begin
                    if (AWVALID_S && aw_ready_q) begin
                        state      <= ST_DATA;
                        b_id_q     <= AWID_S;
                        burst_len  <= AWLEN_S;
                        beat_cnt   <= '0;
                        aw_ready_q <= 1'b0;
                        w_ready_q  <= 1'b1;
                    end
                end

                ST_DATA: begin
                    if (WVALID_S && w_ready_q) begin
                        if (last_beat) begin
                            state     <= ST_RESP;
                            w_ready_q <= 1'b0;
                            b_valid_q <= 1'b1;
                        end else begin
                            beat_cnt <= beat_cnt + 1'b1;
                        end
                    end
                end

                ST_RESP: begin
                    // BID/BVALID hold until the master takes the response.
                    if (BREADY_S && b_valid_q) begin
                        state      <= ST_IDLE;
                        b_valid_q  <= 1'b0;
                        aw_ready_q <= 1'b1;
                    end
                end

                default: begin
                    state      <= ST_INIT;
                    aw_ready_q <= 1'b0;
                    w_ready_q  <= 1'b0;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    assign AWREADY_S = aw_ready_q;
    assign WREADY_S  = w_ready_q;
    assign BVALID_S  = b_valid_q;
    assign BID_S     = b_id_q;
    assign BRESP_S   = RESP_DECERR;

    // Address qualifiers and write payload are accepted but have no effect.
    logic unused_inputs;
    assign unused_inputs = ^{AWADDR_S, AWSIZE_S, AWBURST_S, WDATA_S, WSTRB_S};

endmodule

// File: tb/tb_default_slave_write_resp.sv
module tb_default_slave_write_resp;

    localparam int IDW  = 8;
    localparam int LENW = 4;
    localparam int DW   = 32;

    logic            clk;
    logic            rst_n;
    logic [IDW-1:0]  aw_id;
    logic [31:0]     aw_addr;
    logic [LENW-1:0] aw_len;
    logic [2:0]      aw_size;
    logic [1:0]      aw_burst;
    logic            aw_valid;
    logic            aw_ready;
    logic [DW-1:0]   w_data;
    logic [DW/8-1:0] w_strb;
    logic            w_last;
    logic            w_valid;
    logic            w_ready;
    logic [IDW-1:0]  b_id;
    logic [1:0]      b_resp;
    logic            b_valid;
    logic            b_ready;

    int n_checks = 0;
    int n_pass   = 0;

    default_slave_write_resp #(.IDW(IDW), .LENW(LENW), .DW(DW)) dut (
        .ACLK      (clk),
        .ARESETn   (rst_n),
        .AWID_S    (aw_id),
        .AWADDR_S  (aw_addr),
        .AWLEN_S   (aw_len),
        .AWSIZE_S  (aw_size),
        .AWBURST_S (aw_burst),
        .AWVALID_S (aw_valid),
        .AWREADY_S (aw_ready),
        .WDATA_S   (w_data),
        .WSTRB_S   (w_strb),
        .WLAST_S   (w_last),
        .WVALID_S  (w_valid),
        .WREADY_S  (w_ready),
        .BID_S     (b_id),
        .BRESP_S   (b_resp),
        .BVALID_S  (b_valid),
        .BREADY_S  (b_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Reference rule: the burst ends at the first WLAST or after LEN+1 beats.
    function automatic int exp_beats(input int len, input int wlast_beat);
        if (wlast_beat != 0 && wlast_beat <= len + 1) return wlast_beat;
        return len + 1;
    endfunction

    task automatic idle_inputs();
        aw_valid = 1'b0; w_valid = 1'b0; w_last = 1'b0; b_ready = 1'b0;
    endtask

    // One full write transaction. wv_mode: 0 = WVALID always, 1 = toggling,
    // 2 = random. w_cycles returns the cycles spent in the data phase.
    task automatic run_txn(input string name, input logic [7:0] id, input int len,
                           input int wlast_beat, input int wv_mode, input int b_stall,
                           output int w_cycles);
        int  exp_n, k, cyc;
        bit  hs, done;
        exp_n = exp_beats(len, wlast_beat);

        aw_id    = id;
        aw_len   = len[LENW-1:0];
        aw_addr  = $urandom;
        aw_size  = 3'($urandom);
        aw_burst = 2'($urandom);
        aw_valid = 1'b1;
        w_valid  = 1'b1;  // a beat offered before AW must not be taken
        w_last   = 1'b0;
        cyc = 0;
        while (!aw_ready && cyc < 20) begin step(); cyc++; end
        check({name, ":aw_wait"}, 32'(cyc < 20), 1);
        check({name, ":w_ready_idle"}, w_ready, 0);
        step();
        aw_valid = 1'b0;
        aw_id    = $urandom;  // BID must come from the latched value
        aw_len   = 4'($urandom);
        check({name, ":aw_ready_drop"}, aw_ready, 0);

        k = 0; cyc = 0; done = 0;
        while (!done && cyc < 200) begin
            case (wv_mode)
                0:       w_valid = 1'b1;
                1:       w_valid = (cyc % 2) == 0;
                default: w_valid = 1'($urandom_range(0, 1));
            endcase
            w_last = (wlast_beat == k + 1);
            w_data = $urandom;
            w_strb = 4'($urandom);
            hs = w_valid && w_ready;
            step();
            cyc++;
            if (hs) begin
                k++;
                if (k == exp_n) done = 1;
            end
        end
        w_cycles = cyc;
        w_valid  = 1'b0;
        w_last   = 1'b0;
        check({name, ":beats"}, k, exp_n);
        check({name, ":b_valid_lat"}, b_valid, 1);
        check({name, ":w_ready_end"}, w_ready, 0);
        check({name, ":b_id"}, b_id, id);
        check({name, ":b_resp"}, b_resp, 2'b11);

        b_ready = 1'b0;
        for (int i = 0; i < b_stall; i++) begin
            aw_valid = 1'b1;  // must be refused while a response is pending
            step();
            check({name, ":stall_b_valid"}, b_valid, 1);
            check({name, ":stall_b_id"}, b_id, id);
            check({name, ":stall_b_resp"}, b_resp, 2'b11);
            check({name, ":stall_aw_ready"}, aw_ready, 0);
        end
        aw_valid = 1'b0;
        b_ready  = 1'b1;
        step();
        b_ready = 1'b0;
        check({name, ":b_done"}, b_valid, 0);
        check({name, ":aw_ready_back"}, aw_ready, 1);
    endtask

    initial begin
        int wc;
        int len, wl;

        rst_n = 1'b0;
        aw_id = '0; aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0;
        w_data = '0; w_strb = '0;
        idle_inputs();

        // 1. Reset with inputs toggling
        for (int i = 0; i < 4; i++) begin
            aw_id = $urandom; aw_len = 4'($urandom); aw_valid = 1'($urandom);
            w_valid = 1'($urandom); w_last = 1'($urandom); b_ready = 1'($urandom);
            w_data = $urandom;
            step();
            check("rst:aw_ready", aw_ready, 0);
            check("rst:w_ready", w_ready, 0);
            check("rst:b_valid", b_valid, 0);
            check("rst:b_id", b_id, 0);
            check("rst:b_resp", b_resp, 2'b11);
        end
        idle_inputs();
        rst_n = 1'b1;
        #1;
        check("rst:init_aw_ready", aw_ready, 0);
        step();
        check("rst:aw_ready_up", aw_ready, 1);

        // 2. Single beat, always-ready master: 3 cycles AW, W, B
        run_txn("single", 8'h25, 0, 1, 0, 0, wc);
        check("single:w_cycles", wc, 1);

        // 3. Burst with stalled W and stalled B
        run_txn("stall", 8'h5C, 3, 4, 1, 5, wc);

        // 4. Early WLAST
        run_txn("early", 8'h31, 7, 2, 0, 1, wc);

        // 5. Missing WLAST
        run_txn("nolast", 8'hC3, 2, 0, 0, 0, wc);

        // 6. Reset mid-burst
        aw_id = 8'h77; aw_len = 4'd3; aw_valid = 1'b1;
        while (!aw_ready) step();
        step();
        aw_valid = 1'b0;
        w_valid  = 1'b1;
        step();           // beat 1 accepted
        w_valid = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst:w_ready", w_ready, 0);
        check("midrst:aw_ready", aw_ready, 0);
        check("midrst:b_valid", b_valid, 0);
        check("midrst:b_id", b_id, 0);
        w_valid = 1'b1; w_last = 1'b1;
        step();
        check("midrst:held_b_valid", b_valid, 0);
        idle_inputs();
        rst_n = 1'b1;
        step();
        check("midrst:b_valid_after", b_valid, 0);
        check("midrst:aw_ready_after", aw_ready, 1);
        run_txn("after_rst", 8'h0A, 1, 2, 0, 0, wc);

        // Random transactions against the reference rule
        for (int t = 0; t < 20; t++) begin
            len = $urandom_range(0, 15);
            wl  = $urandom_range(0, len + 2);
            run_txn($sformatf("rnd%0d", t), 8'($urandom), len, wl,
                    $urandom_range(0, 2), $urandom_range(0, 4), wc);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
